// File: rtl/pipelined_controller.sv
// pipelined_controller
// Registered ID/EX control stage for the MIPS-subset CPU. Decodes one
// instruction per cycle into registered datapath controls, raises a
// combinational load-use hazard against the last issued instruction, and
// runs a RUN -> DRAIN -> HALTED sequence when a halt instruction is accepted.
module pipelined_controller #(
    parameter int ALU_OP_W     = 3,
    parameter int STALL_MODE   = 0,
    parameter int DRAIN_CYCLES = 3,
    parameter int HAZARD_EN    = 1
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [31:0]         instruction,
    input  logic                instr_valid,
    input  logic                stall_b,
    input  logic                flush,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_reg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                branch,
    output logic                branch_ne,
    output logic                jump,
    output logic                link,
    output logic [4:0]          dest_reg,
    output logic                illegal,
    output logic                hazard_stall,
    output logic                halt
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // ALU operation codes, zero-extended to the configured width
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_NOP = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6);

    localparam logic [4:0] LINK_REG   = 5'd31;
    localparam logic [3:0] COUNT_INIT = 4'(DRAIN_CYCLES - 1);

    // One ID/EX control slot
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_read;
        logic                mem_write;
        logic                mem_reg;
        logic                reg_write;
        logic                reg_dst;
        logic                alu_src;
        logic                branch;
        logic                branch_ne;
        logic                jump;
        logic                link;
        logic [4:0]          dest_reg;
        logic                illegal;
    } ctrl_t;

    // Bubble: every control low except alu_op, which reads as nop
    localparam ctrl_t BUBBLE = ctrl_t'({ALU_NOP, 16'b0});

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Instruction fields
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       unused_bits;

    assign opcode      = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign rd          = instruction[15:11];
    assign funct       = instruction[5:0];
    // Shift amount is not used by any supported instruction
    assign unused_bits = ^instruction[10:6];

    // Registered state
    state_t     state_q;
    state_t     state_d;
    logic [3:0] count_q;
    logic [3:0] count_d;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic       halt_q;
    logic       halt_d;

    // Decoder results
    ctrl_t dec_ctrl;
    logic  dec_halt;
    logic  uses_rt;
    logic  load_match;

    // Decode the presented instruction into a control slot
    // NOTE: every combinational output gets a default first, so no path
    // through the case statements can leave a latch behind.
    always_comb begin
        dec_ctrl = BUBBLE;
        dec_halt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.dest_reg  = rd;
                case (funct)
                    FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
                    FN_AND:  dec_ctrl.alu_op = ALU_AND;
                    FN_OR:   dec_ctrl.alu_op = ALU_OR;
                    FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
                    default: begin
                        dec_ctrl         = BUBBLE;
                        dec_ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.mem_reg   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
                dec_ctrl.dest_reg  = rt;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
                dec_ctrl.dest_reg  = rt;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec_ctrl.branch_ne = 1'b1;
                dec_ctrl.alu_op    = ALU_SUB;
            end
            OP_J: begin
                dec_ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.link      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.dest_reg  = LINK_REG;
            end
            OP_HALT: begin
                dec_halt = 1'b1;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Load-use detection against the slot issued last cycle
    always_comb begin
        uses_rt    = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);
        load_match = ctrl_q.mem_read && (ctrl_q.dest_reg != 5'd0) &&
                     ((ctrl_q.dest_reg == rs) ||
                      (uses_rt && (ctrl_q.dest_reg == rt)));
        hazard_stall = (HAZARD_EN != 0) && load_match && !flush && stall_b &&
                       (state_q == RUN) && instr_valid;
    end

    // Next-state and next-slot selection in priority order
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ctrl_d  = BUBBLE;
        halt_d  = halt_q;
        if (flush) begin
            // A halt still draining was on the wrong path; resume
            if (state_q == DRAIN) begin
                state_d = RUN;
                count_d = 4'd0;
            end
        end else if (state_q != RUN) begin
            if (state_q == DRAIN) begin
                if (count_q == 4'd0) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end else if (!stall_b) begin
            if (STALL_MODE != 0) begin
                // Hold the issued slot, but an illegal report is a single pulse
                ctrl_d         = ctrl_q;
                ctrl_d.illegal = 1'b0;
            end
        end else if (hazard_stall) begin
            ctrl_d = BUBBLE;
        end else if (instr_valid) begin
            if (dec_halt) begin
                state_d = DRAIN;
                count_d = COUNT_INIT;
            end else begin
                ctrl_d = dec_ctrl;
            end
        end
    end

    // State register and registered control slot, synchronous reset
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= RUN;
            count_q <= 4'd0;
            ctrl_q  <= BUBBLE;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            halt_q  <= halt_d;
        end
    end

    assign alu_op    = ctrl_q.alu_op;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign mem_reg   = ctrl_q.mem_reg;
    assign reg_write = ctrl_q.reg_write;
    assign reg_dst   = ctrl_q.reg_dst;
    assign alu_src   = ctrl_q.alu_src;
    assign branch    = ctrl_q.branch;
    assign branch_ne = ctrl_q.branch_ne;
    assign jump      = ctrl_q.jump;
    assign link      = ctrl_q.link;
    assign dest_reg  = ctrl_q.dest_reg;
    assign illegal   = ctrl_q.illegal;
    assign halt      = halt_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller
// Drives directed vectors into two controllers (bubble and hold stall modes)
// in parallel. Each driven cycle pushes its hand-computed expectation into a
// scoreboard queue; a monitor pops one entry per clock and compares.
module tb_pipelined_controller;

    typedef struct packed {
        logic       halt;
        logic       illegal;
        logic [4:0] dest;
        logic       link;
        logic       jump;
        logic       bne;
        logic       beq;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_reg;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] alu_op;
    } ctl_t;

    typedef struct {
        string name;
        logic  hz0;
        logic  hz1;
        ctl_t  e0;
        ctl_t  e1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall_b;
    logic        flush;

    logic [2:0] alu_op [2];
    logic [4:0] dest_reg [2];
    logic [1:0] mem_read, mem_write, mem_reg, reg_write, reg_dst, alu_src;
    logic [1:0] branch, branch_ne, jump, link, illegal, hazard_stall, halt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    ctl_t BUB, BUBH, ILL, ADD3, ADD4, ADD6, SUB7, LW5, LW0, ADDI5, SW;
    ctl_t BEQ, BNE, J, JAL, AND8, OR9, SLT10;

    always #5 clk = ~clk;

    pipelined_controller #(.ALU_OP_W(3), .STALL_MODE(0), .DRAIN_CYCLES(3), .HAZARD_EN(1)) dut0 (
        .clk(clk), .rst_b(rst_b), .instruction(instruction), .instr_valid(instr_valid),
        .stall_b(stall_b), .flush(flush), .alu_op(alu_op[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .mem_reg(mem_reg[0]), .reg_write(reg_write[0]),
        .reg_dst(reg_dst[0]), .alu_src(alu_src[0]), .branch(branch[0]),
        .branch_ne(branch_ne[0]), .jump(jump[0]), .link(link[0]), .dest_reg(dest_reg[0]),
        .illegal(illegal[0]), .hazard_stall(hazard_stall[0]), .halt(halt[0])
    );

    pipelined_controller #(.ALU_OP_W(3), .STALL_MODE(1), .DRAIN_CYCLES(3), .HAZARD_EN(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .instruction(instruction), .instr_valid(instr_valid),
        .stall_b(stall_b), .flush(flush), .alu_op(alu_op[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .mem_reg(mem_reg[1]), .reg_write(reg_write[1]),
        .reg_dst(reg_dst[1]), .alu_src(alu_src[1]), .branch(branch[1]),
        .branch_ne(branch_ne[1]), .jump(jump[1]), .link(link[1]), .dest_reg(dest_reg[1]),
        .illegal(illegal[1]), .hazard_stall(hazard_stall[1]), .halt(halt[1])
    );

    function automatic ctl_t observed(input int k);
        ctl_t c;
        c.halt      = halt[k];
        c.illegal   = illegal[k];
        c.dest      = dest_reg[k];
        c.link      = link[k];
        c.jump      = jump[k];
        c.bne       = branch_ne[k];
        c.beq       = branch[k];
        c.alu_src   = alu_src[k];
        c.reg_dst   = reg_dst[k];
        c.reg_write = reg_write[k];
        c.mem_reg   = mem_reg[k];
        c.mem_write = mem_write[k];
        c.mem_read  = mem_read[k];
        c.alu_op    = alu_op[k];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what both controllers must show
    task automatic step2(input string name, input logic [31:0] ins, input logic vld,
                         input logic stl, input logic fl, input logic rst,
                         input logic hz0, input logic hz1, input ctl_t e0, input ctl_t e1);
        exp_t r;
        @(negedge clk);
        instruction = ins;
        instr_valid = vld;
        stall_b     = stl;
        flush       = fl;
        rst_b       = rst;
        r.name = name;
        r.hz0  = hz0;
        r.hz1  = hz1;
        r.e0   = e0;
        r.e1   = e1;
        sb.push_back(r);
    endtask

    task automatic step(input string name, input logic [31:0] ins, input logic vld,
                        input logic stl, input logic fl, input logic rst,
                        input logic hz, input ctl_t e);
        step2(name, ins, vld, stl, fl, rst, hz, hz, e, e);
    endtask

    // Monitor: hazard mid-cycle, registered controls just after the edge
    initial begin
        exp_t r;
        logic h0, h1;
        ctl_t a0, a1;
        forever begin
            @(negedge clk);
            #2;
            h0 = hazard_stall[0];
            h1 = hazard_stall[1];
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                r  = sb.pop_front();
                a0 = observed(0);
                a1 = observed(1);
                check({r.name, "/hz_m0"}, 32'(h0), 32'(r.hz0));
                check({r.name, "/ctl_m0"}, 32'(a0), 32'(r.e0));
                check({r.name, "/hz_m1"}, 32'(h1), 32'(r.hz1));
                check({r.name, "/ctl_m1"}, 32'(a1), 32'(r.e1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] I_ADD3  = 32'h00221820;
    localparam logic [31:0] I_LW5   = 32'h8C250000;
    localparam logic [31:0] I_ADD6  = 32'h00A23020;
    localparam logic [31:0] I_SUB7  = 32'h00223822;
    localparam logic [31:0] I_ADDI5 = 32'h21250001;
    localparam logic [31:0] I_SW5   = 32'hAD250000;
    localparam logic [31:0] I_LW0   = 32'h8C200000;
    localparam logic [31:0] I_ADD4  = 32'h00002020;
    localparam logic [31:0] I_BEQ   = 32'h10220004;
    localparam logic [31:0] I_BNE   = 32'h14220004;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_AND8  = 32'h00224024;
    localparam logic [31:0] I_OR9   = 32'h00224825;
    localparam logic [31:0] I_SLT10 = 32'h0022502A;
    localparam logic [31:0] I_BADOP = 32'hF8000000;
    localparam logic [31:0] I_BADFN = 32'h0000003F;
    localparam logic [31:0] I_HALT  = 32'hFC000000;

    initial begin
        BUB = '0;  BUB.alu_op = 3'd1;
        BUBH = BUB; BUBH.halt = 1'b1;
        ILL = BUB;  ILL.illegal = 1'b1;
        ADD3 = '0; ADD3.reg_write = 1'b1; ADD3.reg_dst = 1'b1; ADD3.dest = 5'd3;
        ADD4 = ADD3; ADD4.dest = 5'd4;
        ADD6 = ADD3; ADD6.dest = 5'd6;
        SUB7 = ADD3; SUB7.dest = 5'd7; SUB7.alu_op = 3'd6;
        AND8 = ADD3; AND8.dest = 5'd8; AND8.alu_op = 3'd2;
        OR9  = ADD3; OR9.dest = 5'd9;  OR9.alu_op = 3'd3;
        SLT10 = ADD3; SLT10.dest = 5'd10; SLT10.alu_op = 3'd4;
        LW5 = '0; LW5.mem_read = 1'b1; LW5.mem_reg = 1'b1; LW5.reg_write = 1'b1;
        LW5.alu_src = 1'b1; LW5.dest = 5'd5;
        LW0 = LW5; LW0.dest = 5'd0;
        ADDI5 = '0; ADDI5.reg_write = 1'b1; ADDI5.alu_src = 1'b1; ADDI5.dest = 5'd5;
        SW = '0; SW.mem_write = 1'b1; SW.alu_src = 1'b1;
        BEQ = '0; BEQ.beq = 1'b1; BEQ.alu_op = 3'd6;
        BNE = '0; BNE.bne = 1'b1; BNE.alu_op = 3'd6;
        J = BUB; J.jump = 1'b1;
        JAL = J; JAL.link = 1'b1; JAL.reg_write = 1'b1; JAL.dest = 5'd31;

        rst_b = 1'b0; instruction = '0; instr_valid = 1'b0; stall_b = 1'b1; flush = 1'b0;

        //    name          instr    vld  stl  fl   rst  hz    expected
        step("reset0",      I_ADD3,  0,   1,   0,   0,   0,    BUB);
        step("reset1",      I_ADD3,  0,   1,   0,   0,   0,    BUB);
        step("add3",        I_ADD3,  1,   1,   0,   1,   0,    ADD3);
        step("lw5",         I_LW5,   1,   1,   0,   1,   0,    LW5);
        step("add6_hz_rs",  I_ADD6,  1,   1,   0,   1,   1,    BUB);
        step("add6_issue",  I_ADD6,  1,   1,   0,   1,   0,    ADD6);
        step("sub7",        I_SUB7,  1,   1,   0,   1,   0,    SUB7);
        step("lw5_b",       I_LW5,   1,   1,   0,   1,   0,    LW5);
        step("addi5_no_hz", I_ADDI5, 1,   1,   0,   1,   0,    ADDI5);
        step("lw5_c",       I_LW5,   1,   1,   0,   1,   0,    LW5);
        step("sw_hz_rt",    I_SW5,   1,   1,   0,   1,   1,    BUB);
        step("sw_issue",    I_SW5,   1,   1,   0,   1,   0,    SW);
        step("lw0",         I_LW0,   1,   1,   0,   1,   0,    LW0);
        step("add4_r0",     I_ADD4,  1,   1,   0,   1,   0,    ADD4);
        step("lw5_d",       I_LW5,   1,   1,   0,   1,   0,    LW5);
        step("flush_hz",    I_ADD6,  1,   1,   1,   1,   0,    BUB);
        step("lw5_e",       I_LW5,   1,   1,   0,   1,   0,    LW5);
        step("invalid_hz",  I_ADD6,  0,   1,   0,   1,   0,    BUB);
        step("add6_b",      I_ADD6,  1,   1,   0,   1,   0,    ADD6);
        step("lw5_f",       I_LW5,   1,   1,   0,   1,   0,    LW5);
        step2("stall_0",    I_ADD6,  1,   0,   0,   1,   0, 0, BUB, LW5);
        step2("stall_1",    I_ADD6,  1,   0,   0,   1,   0, 0, BUB, LW5);
        step2("unstall",    I_ADD6,  1,   1,   0,   1,   0, 1, ADD6, BUB);
        step("add6_c",      I_ADD6,  1,   1,   0,   1,   0,    ADD6);
        step("beq",         I_BEQ,   1,   1,   0,   1,   0,    BEQ);
        step("bne",         I_BNE,   1,   1,   0,   1,   0,    BNE);
        step("j",           I_J,     1,   1,   0,   1,   0,    J);
        step("jal",         I_JAL,   1,   1,   0,   1,   0,    JAL);
        step("and8",        I_AND8,  1,   1,   0,   1,   0,    AND8);
        step("or9",         I_OR9,   1,   1,   0,   1,   0,    OR9);
        step("slt10",       I_SLT10, 1,   1,   0,   1,   0,    SLT10);
        step("bad_op",      I_BADOP, 1,   1,   0,   1,   0,    ILL);
        step("after_badop", I_ADD3,  1,   1,   0,   1,   0,    ADD3);
        step("bad_funct",   I_BADFN, 1,   1,   0,   1,   0,    ILL);
        step("after_badfn", I_ADD3,  0,   1,   0,   1,   0,    BUB);
        step("halt_wrong",  I_HALT,  1,   1,   0,   1,   0,    BUB);
        step("flush_drain", I_BEQ,   1,   1,   1,   1,   0,    BUB);
        step("beq_resume",  I_BEQ,   1,   1,   0,   1,   0,    BEQ);
        step("idle0",       I_ADD3,  0,   1,   0,   1,   0,    BUB);
        step("idle1",       I_ADD3,  0,   1,   0,   1,   0,    BUB);
        step("idle2",       I_ADD3,  0,   1,   0,   1,   0,    BUB);
        step("halt_edge1",  I_HALT,  1,   1,   0,   1,   0,    BUB);
        step("drain_edge2", I_ADD3,  1,   1,   0,   1,   0,    BUB);
        step("drain_edge3", I_ADD3,  1,   1,   0,   1,   0,    BUB);
        step("halt_edge4",  I_ADD3,  1,   1,   0,   1,   0,    BUBH);
        step("halted_flush",I_ADD3,  1,   1,   1,   1,   0,    BUBH);
        step("reset_halt",  I_ADD3,  1,   1,   0,   0,   0,    BUB);
        step("add3_b",      I_ADD3,  1,   1,   0,   1,   0,    ADD3);
        step("halt_again",  I_HALT,  1,   1,   0,   1,   0,    BUB);
        step("reset_drain", I_ADD3,  1,   1,   0,   0,   0,    BUB);
        step("add3_c",      I_ADD3,  1,   1,   0,   1,   0,    ADD3);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
